// File: rtl/cc_rd_reg_init_if.sv
// -----------------------------------------------------------------------------
// cc_rd_reg_init_if
// Purpose : Bundles the outbound command stream (TX) and the inbound response
//           stream (RX) between the CC_RD_REG initiator and the channel link
//           FIFOs.
// Signals :
//   tx_tdata  [31:0]  outbound command word
//   tx_tvalid         outbound word valid
//   tx_tlast          final word of the command packet
//   tx_tready         TX FIFO accepts the word
//   rx_tdata  [31:0]  inbound response word
//   rx_tvalid         inbound word valid
//   rx_tlast          final word of the response frame
//   rx_tready         initiator consumes the inbound word
// Modports:
//   master  - the initiator (drives TX payload, drives RX ready)
//   slave   - the FIFO side (drives TX ready, drives RX payload)
// -----------------------------------------------------------------------------
interface cc_rd_reg_init_if;
  logic [31:0] tx_tdata;
  logic        tx_tvalid;
  logic        tx_tlast;
  logic        tx_tready;
  logic [31:0] rx_tdata;
  logic        rx_tvalid;
  logic        rx_tlast;
  logic        rx_tready;

  modport master (
    output tx_tdata,
    output tx_tvalid,
    output tx_tlast,
    input  tx_tready,
    input  rx_tdata,
    input  rx_tvalid,
    input  rx_tlast,
    output rx_tready
  );

  modport slave (
    input  tx_tdata,
    input  tx_tvalid,
    input  tx_tlast,
    output tx_tready,
    output rx_tdata,
    output rx_tvalid,
    output rx_tlast,
    input  rx_tready
  );
endinterface

// File: rtl/cc_rd_reg_init.sv
// -----------------------------------------------------------------------------
// cc_rd_reg_init
// Purpose : Initiator side of the CC_RD_REG channel command. A start pulse
//           sends the 3-word command packet {CSN, CC, register number}, then
//           the response frame {RSN, RC, data} is received and checked. The
//           register contents or an error status is returned to the local
//           controller.
// Ports   :
//   clk            in   local clock
//   rst_n          in   asynchronous active-low reset
//   i_start        in   one-cycle read request, ignored while busy
//   i_reg_num[3:0] in   register number, sampled when start is accepted
//   o_busy         out  high from accepted start through the done cycle
//   o_done         out  one-cycle completion pulse
//   o_status[1:0]  out  0=OK 1=error response 2=protocol error 3=timeout
//   o_rd_data[31:0]out  register contents, valid when done and status is 0
//   link           master modport of cc_rd_reg_init_if (TX and RX streams)
// -----------------------------------------------------------------------------
module cc_rd_reg_init #(
  parameter logic [31:0] CC_RD_REG      = 32'h0000_0002,
  parameter int          CSN_WIDTH      = 16,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic [3:0]          i_reg_num,
  output logic                o_busy,
  output logic                o_done,
  output logic [1:0]          o_status,
  output logic [31:0]         o_rd_data,
  cc_rd_reg_init_if.master    link
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] CC_INV = ~CC_RD_REG;

  localparam logic [1:0] ST_OK       = 2'd0;
  localparam logic [1:0] ST_ERR_RESP = 2'd1;
  localparam logic [1:0] ST_PROTO    = 2'd2;
  localparam logic [1:0] ST_TIMEOUT  = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SEND_CSN,
    S_SEND_CC,
    S_SEND_REG,
    S_WAIT_RSN,
    S_WAIT_RC,
    S_WAIT_DATA,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [CSN_WIDTH-1:0] r_csn;
  logic [CSN_WIDTH-1:0] w_csn_next;
  logic [3:0]           r_reg_num;
  logic [3:0]           w_reg_num_next;
  logic [1:0]           r_status;
  logic [1:0]           w_status_next;
  logic [31:0]          r_rd_data;
  logic [31:0]          w_rd_data_next;
  logic [TMO_W-1:0]     r_tmo;
  logic [TMO_W-1:0]     w_tmo_next;

  logic [31:0]          w_csn_word;
  logic                 w_tx_valid;
  logic                 w_rx_wait;
  logic                 w_tx_fire;
  logic                 w_rx_fire;
  logic [31:0]          w_tx_data;

  // CSN travels zero-extended to a full bus word.
  assign w_csn_word = 32'(r_csn);

  assign w_tx_valid = (r_state == S_SEND_CSN) || (r_state == S_SEND_CC) ||
                      (r_state == S_SEND_REG);
  assign w_rx_wait  = (r_state == S_WAIT_RSN) || (r_state == S_WAIT_RC) ||
                      (r_state == S_WAIT_DATA) || (r_state == S_FLUSH);
  assign w_tx_fire  = w_tx_valid & link.tx_tready;
  assign w_rx_fire  = w_rx_wait & link.rx_tvalid;

  // TX payload is a pure function of state and latched fields, so it cannot
  // change while a word is stalled waiting for tx_tready.
  always_comb begin
    w_tx_data = '0;
    unique case (r_state)
      S_SEND_CSN: w_tx_data = w_csn_word;
      S_SEND_CC:  w_tx_data = CC_RD_REG;
      S_SEND_REG: w_tx_data = {28'b0, r_reg_num};
      default:    w_tx_data = '0;
    endcase
  end

  assign link.tx_tdata  = w_tx_data;
  assign link.tx_tvalid = w_tx_valid;
  assign link.tx_tlast  = (r_state == S_SEND_REG);
  assign link.rx_tready = w_rx_wait;

  assign o_busy    = (r_state != S_IDLE);
  assign o_done    = (r_state == S_DONE);
  assign o_status  = r_status;
  assign o_rd_data = r_rd_data;

  // Next-state and datapath updates.
  always_comb begin
    w_state_next   = r_state;
    w_csn_next     = r_csn;
    w_reg_num_next = r_reg_num;
    w_status_next  = r_status;
    w_rd_data_next = r_rd_data;
    w_tmo_next     = r_tmo;

    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_reg_num_next = i_reg_num;
          w_status_next  = ST_OK;
          w_rd_data_next = '0;
          w_state_next   = S_SEND_CSN;
        end
      end

      S_SEND_CSN: begin
        if (w_tx_fire) w_state_next = S_SEND_CC;
      end

      S_SEND_CC: begin
        if (w_tx_fire) w_state_next = S_SEND_REG;
      end

      S_SEND_REG: begin
        if (w_tx_fire) begin
          w_tmo_next   = '0;
          w_state_next = S_WAIT_RSN;
        end
      end

      S_WAIT_RSN: begin
        if (w_rx_fire) begin
          // A wrong RSN, or a frame that ends on the RSN, is a protocol error.
          if ((link.rx_tdata != w_csn_word) || link.rx_tlast) begin
            w_status_next = ST_PROTO;
            w_state_next  = link.rx_tlast ? S_DONE : S_FLUSH;
          end else begin
            w_state_next  = S_WAIT_RC;
          end
        end
      end

      S_WAIT_RC: begin
        if (w_rx_fire) begin
          if ((link.rx_tdata == CC_RD_REG) && !link.rx_tlast) begin
            w_state_next  = S_WAIT_DATA;
          end else if ((link.rx_tdata == CC_INV) && link.rx_tlast) begin
            w_status_next = ST_ERR_RESP;
            w_state_next  = S_DONE;
          end else begin
            // Wrong RC, or a well-formed RC in a frame of the wrong length.
            w_status_next = ST_PROTO;
            w_state_next  = link.rx_tlast ? S_DONE : S_FLUSH;
          end
        end
      end

      S_WAIT_DATA: begin
        if (w_rx_fire) begin
          // Data is captured even when the frame is too long; status then
          // marks it as not valid.
          w_rd_data_next = link.rx_tdata;
          if (link.rx_tlast) begin
            w_state_next  = S_DONE;
          end else begin
            w_status_next = ST_PROTO;
            w_state_next  = S_FLUSH;
          end
        end
      end

      S_FLUSH: begin
        if (w_rx_fire && link.rx_tlast) w_state_next = S_DONE;
      end

      S_DONE: begin
        // Every completed command consumes a serial number, whatever status.
        w_csn_next   = r_csn + 1'b1;
        w_state_next = S_IDLE;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // Inter-word watchdog on the response side. Any accepted word restarts
    // it; a silent link for TIMEOUT_CYCLES cycles ends the command.
    if (w_rx_fire) begin
      w_tmo_next = '0;
    end else if (w_rx_wait) begin
      if (r_tmo == TMO_LAST) begin
        w_status_next = ST_TIMEOUT;
        w_state_next  = S_DONE;
      end else begin
        w_tmo_next = r_tmo + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_csn     <= '0;
      r_reg_num <= '0;
      r_status  <= '0;
      r_rd_data <= '0;
      r_tmo     <= '0;
    end else begin
      r_state   <= w_state_next;
      r_csn     <= w_csn_next;
      r_reg_num <= w_reg_num_next;
      r_status  <= w_status_next;
      r_rd_data <= w_rd_data_next;
      r_tmo     <= w_tmo_next;
    end
  end

endmodule
